booth_radix4_multiplier: RTL and testbench



---
 rtl/booth_pkg.sv | 40 ++++
 rtl/booth_r4_recoder.sv | 29 ++
 rtl/booth_radix4_multiplier.sv | 138 +++++++++++++
 tb/tb_booth_radix4_multiplier.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// UNSIGNED_MODE_EN adds one iteration so zero-extended operands are fully consumed.
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        DigZero,
        DigPos1,
        DigPos2,
        DigNeg1,
        DigNeg2
    } digit_e;

    function automatic int unsigned booth_iters(input int unsigned width);
`ifdef UNSIGNED_MODE_EN
        return width / 2 + 1;
`else
        return width / 2;
`endif
    endfunction

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic digit_e booth_decode(input logic [2:0] trip);
        digit_e dig;
        case (trip)
            3'b001, 3'b010: dig = DigPos1;
            3'b011:         dig = DigPos2;
            3'b100:         dig = DigNeg2;
            3'b101, 3'b110: dig = DigNeg1;
            default:        dig = DigZero;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational radix-4 Booth recoder: maps a multiplier triplet to the partial product
// digit * mcand, formed at the extended operand width.
module booth_r4_recoder
    import booth_pkg::*;
#(
    parameter int unsigned EXT_WIDTH = 10
) (
    input  logic [2:0]           triplet,
    input  logic [EXT_WIDTH-1:0] mcand,
    output logic [EXT_WIDTH-1:0] pp
);

    digit_e digit;

    assign digit = booth_decode(triplet);

    always_comb begin
        pp = '0;
        unique case (digit)
            DigZero: pp = '0;
            DigPos1: pp = mcand;
            DigPos2: pp = mcand << 1;
            DigNeg1: pp = -mcand;
            DigNeg2: pp = -(mcand << 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier with start/busy/done handshake.
// Optional UNSIGNED_MODE_EN adds the is_signed input (zero-extension when low).
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef UNSIGNED_MODE_EN
    input  logic                 is_signed,
`endif
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned EXT_W = WIDTH + 2;
    // Running sum can reach ~8/3 |a|, so the upper field carries extra guard bits.
    localparam int unsigned HI_W  = WIDTH + 4;
    localparam int unsigned ITERS = booth_iters(WIDTH);
    localparam int unsigned LO_W  = 2 * ITERS;
    localparam int unsigned ACC_W = HI_W + LO_W;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
        $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
    end

    state_e               state_q, state_d;
    logic [EXT_W-1:0]     mcand_q, mcand_d;
    logic [EXT_W-1:0]     mplier_q, mplier_d;
    logic                 prev_q, prev_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 fill_a, fill_b;
    logic [EXT_W-1:0]     a_ext, b_ext;
    logic [EXT_W-1:0]     pp;
    logic [HI_W-1:0]      hi_sum;
    logic [ACC_W-1:0]     acc_step;
    logic                 accept;

`ifdef UNSIGNED_MODE_EN
    assign fill_a = is_signed & a[WIDTH-1];
    assign fill_b = is_signed & b[WIDTH-1];
`else
    assign fill_a = a[WIDTH-1];
    assign fill_b = b[WIDTH-1];
`endif

    assign a_ext = {{2{fill_a}}, a};
    assign b_ext = {{2{fill_b}}, b};

    booth_r4_recoder #(
        .EXT_WIDTH (EXT_W)
    ) u_recoder (
        .triplet (({mplier_q[1:0], prev_q})),
        .mcand   (mcand_q),
        .pp      (pp)
    );

    // Add the partial product into the upper field, then shift the whole accumulator by 2.
    assign hi_sum   = acc_q[ACC_W-1 -: HI_W] + {{(HI_W - EXT_W){pp[EXT_W-1]}}, pp};
    assign acc_step = $signed({hi_sum, acc_q[LO_W-1:0]}) >>> 2;

    assign accept = start && (state_q != StCalc);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StCalc: begin
                acc_d    = acc_step;
                prev_d   = mplier_q[1];
                mplier_d = $signed(mplier_q) >>> 2;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = StDone;
                    product_d = acc_step[2*WIDTH-1:0];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d  = StCalc;
            mcand_d  = a_ext;
            mplier_d = b_ext;
            prev_d   = 1'b0;
            cnt_d    = CNT_W'(ITERS);
            acc_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == StCalc);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier against a plain-arithmetic product model.
// Exercises the is_signed input when UNSIGNED_MODE_EN is defined.
module tb_booth_radix4_multiplier;

    localparam int unsigned WIDTH = 8;
`ifdef UNSIGNED_MODE_EN
    localparam int unsigned ITERS = WIDTH / 2 + 1;
`else
    localparam int unsigned ITERS = WIDTH / 2;
`endif
    localparam int unsigned PW = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
`ifdef UNSIGNED_MODE_EN
    logic             is_signed;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [PW-1:0]    product;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [PW-1:0] last_exp = '0;

    always #5 clk = ~clk;

    booth_radix4_multiplier #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef UNSIGNED_MODE_EN
        .is_signed (is_signed),
`endif
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product)
    );

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input bit sgn);
        longint xv, yv;
        if (sgn) begin
            xv = longint'($signed(x));
            yv = longint'($signed(y));
        end else begin
            xv = longint'(x);
            yv = longint'(y);
        end
        return PW'(xv * yv);
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        logic [WIDTH-1:0] corner [5];
        corner[0] = {1'b1, {(WIDTH-1){1'b0}}};
        corner[1] = {1'b0, {(WIDTH-1){1'b1}}};
        corner[2] = '1;
        corner[3] = '0;
        corner[4] = WIDTH'(1);
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return WIDTH'($urandom);
    endfunction

    // Called at a negedge: issues start, optionally pokes start while busy, waits for done.
    // Returns at the negedge where done is visible.
    task automatic do_mul(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit sgn,
                          input bit poke);
        logic [PW-1:0] expv;
        int cycles;
        int busy_cycles;
        expv  = ref_mul(av, bv, sgn);
        a     = av;
        b     = bv;
        start = 1'b1;
`ifdef UNSIGNED_MODE_EN
        is_signed = sgn;
`endif
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        check_eq("hold_while_busy", product, last_exp);
        cycles      = 0;
        busy_cycles = 0;
        while (!done && cycles < 4 * ITERS + 4) begin
            if (busy) busy_cycles++;
            start = poke && busy && ($urandom_range(0, 1) == 1);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
`ifdef UNSIGNED_MODE_EN
            if (poke) is_signed = $urandom_range(0, 1) == 1;
`endif
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check_eq("latency", cycles, ITERS);
        check_eq("busy_cycles", busy_cycles, ITERS);
        check_eq("product", product, expv);
        last_exp = expv;
    endtask

    task automatic finish_op();
        @(negedge clk);
        check_eq("done_single_pulse", done, 1'b0);
        check_eq("idle_not_busy", busy, 1'b0);
        check_eq("product_hold", product, last_exp);
    endtask

    initial begin
        logic [WIDTH-1:0] da [6];
        logic [WIDTH-1:0] db [6];
        bit sgn;
        bit seen_done;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef UNSIGNED_MODE_EN
        is_signed = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_product", product, '0);
        rst_n = 1'b1;
        @(negedge clk);

        da = '{8'd2, 8'h80, 8'h80, 8'h00, 8'hFF, 8'h03};
        db = '{8'd5, 8'h80, 8'h7F, 8'hFF, 8'hFF, 8'h03};
        for (int i = 0; i < 6; i++) begin
            do_mul(da[i], db[i], 1'b1, 1'b0);
            finish_op();
        end
        repeat (4) @(negedge clk);
        check_eq("product_hold_idle", product, last_exp);

        // Start pulses during CALC must be ignored.
        do_mul(8'd3, 8'd7, 1'b1, 1'b1);
        finish_op();

        // Back-to-back: start driven in the DONE cycle.
        do_mul(8'd11, 8'hF3, 1'b1, 1'b0);
        do_mul(8'h7F, 8'h7F, 1'b1, 1'b0);
        finish_op();

        // Reset in the second CALC cycle.
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_busy", busy, 1'b0);
        check_eq("midreset_product", product, '0);
        seen_done = 1'b0;
        for (int i = 0; i < ITERS + 2; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check_eq("midreset_no_done", seen_done, 1'b0);
        rst_n = 1'b1;
        last_exp = '0;
        @(negedge clk);
        do_mul(8'd9, 8'hF7, 1'b1, 1'b0);
        finish_op();

`ifdef UNSIGNED_MODE_EN
        do_mul(8'hFF, 8'hFF, 1'b0, 1'b0);
        finish_op();
        do_mul(8'hFF, 8'hFF, 1'b1, 1'b0);
        finish_op();
        do_mul(8'h80, 8'h80, 1'b0, 1'b0);
        finish_op();
`endif

        for (int i = 0; i < 40; i++) begin
            sgn = 1'b1;
`ifdef UNSIGNED_MODE_EN
            sgn = $urandom_range(0, 1) == 1;
`endif
            do_mul(pick_operand(), pick_operand(), sgn, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) != 0) finish_op();
        end
        finish_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
